ntt_coef_io: RTL and testbench

Coefficient I/O sequencer for the NTT core's 18-bit × 8192 polynomial RAM. It loads N coefficients from an input valid/ready stream into the RAM, reducing each signed input into [0, Q). It unloads N coefficients from the RAM to an output valid/ready stream, hiding the RAM's one-cycle registered-address read latency behind a 2-entry output buffer. It drives the RAM's write port and read port directly and sits between the host-side streams and the RAM.

---
 rtl/ntt_coef_io.sv | 138 +++++++++++++
 tb/tb_ntt_coef_io.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ntt_coef_io.sv
// Coefficient load/unload sequencer between host valid/ready streams and the NTT polynomial RAM.
// Define NTT_COEF_BITREV_EN to scatter LOAD writes to bit-reversed addresses (unload stays natural).
module ntt_coef_io #(
  parameter int N_LOG  = 13,
  parameter int Q      = 65537,
  parameter int DATA_W = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_load,
  input  logic                     start_unload,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     ram_wr_en,
  output logic [N_LOG-1:0]         ram_wr_addr,
  output logic [DATA_W-1:0]        ram_wr_din,
  output logic [N_LOG-1:0]         ram_rd_addr,
  input  logic [DATA_W-1:0]        ram_rd_dout
);

  localparam int CW = N_LOG + 1;
  localparam logic [CW-1:0] LAST = {1'b0, {N_LOG{1'b1}}};
  localparam logic signed [DATA_W-1:0] Q_S = DATA_W'(Q);

  typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              rd_vld_p1;
  logic [1:0]        occ;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;

  logic              in_hs, pop, issue, last_pop, store, drain;
  logic [2:0]        fill_now, fill_nxt;

  function automatic logic [DATA_W-1:0] reduce_q(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] r;
    r = (x < 0) ? x + Q_S : x;
    return $unsigned(r);
  endfunction

`ifdef NTT_COEF_BITREV_EN
  function automatic logic [N_LOG-1:0] load_addr(input logic [N_LOG-1:0] c);
    logic [N_LOG-1:0] r;
    for (int i = 0; i < N_LOG; i++) r[i] = c[N_LOG-1-i];
    return r;
  endfunction
`else
  function automatic logic [N_LOG-1:0] load_addr(input logic [N_LOG-1:0] c);
    return c;
  endfunction
`endif

  // Occupancy counts the word arriving from the RAM this cycle as already buffered,
  // so the read result can bypass straight to the output.
  assign out_valid = (occ != 2'd0) | rd_vld_p1;
  assign out_data  = (occ != 2'd0) ? fifo_mem[rd_ptr] :
                     (rd_vld_p1 ? ram_rd_dout : '0);

  assign in_hs    = (state == LOAD) & in_valid;
  assign pop      = out_valid & out_ready;
  assign fill_now = 3'(occ) + 3'(rd_vld_p1);
  assign fill_nxt = fill_now - 3'(pop);
  assign issue    = (state == UNLOAD) & ~cnt[N_LOG] & (fill_nxt < 3'd2);
  assign last_pop = pop & cnt[N_LOG] & (fill_now == 3'd1);
  assign store    = rd_vld_p1 & ~((occ == 2'd0) & pop);
  assign drain    = pop & (occ != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = (state != IDLE);
    done        = 1'b0;
    in_ready    = 1'b0;
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_din  = '0;
    ram_rd_addr = '0;
    case (state)
      IDLE: begin
        if (start_load)        state_nxt = LOAD;
        else if (start_unload) state_nxt = UNLOAD;
      end
      LOAD: begin
        in_ready    = 1'b1;
        ram_wr_en   = in_valid;
        ram_wr_addr = load_addr(cnt[N_LOG-1:0]);
        ram_wr_din  = reduce_q(in_data);
        if (in_valid && cnt == LAST) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      UNLOAD: begin
        ram_rd_addr = cnt[N_LOG-1:0];
        if (last_pop) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0: address issue / count; p1: read data returns and enters the buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rd_vld_p1 <= 1'b0;
      occ       <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else begin
      if (state == IDLE)      cnt <= '0;
      else if (in_hs | issue) cnt <= cnt + 1'b1;
      rd_vld_p1 <= issue;
      occ       <= 2'(fill_nxt);
      if (store) wr_ptr <= ~wr_ptr;
      if (drain) rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (store) fifo_mem[wr_ptr] <= ram_rd_dout;
  end

endmodule

// File: tb/tb_ntt_coef_io.sv
// Scoreboard bench for ntt_coef_io with a behavioural registered-read RAM, N_LOG = 4.
module tb_ntt_coef_io;
  localparam int N_LOG = 4;
  localparam int N     = 16;
  localparam int Q     = 65537;

  logic        clk, rst, start_load, start_unload, busy, done;
  logic        in_valid, in_ready, out_valid, out_ready, ram_wr_en;
  logic signed [17:0] in_data;
  logic [17:0] out_data, ram_wr_din, ram_rd_dout, rd_q;
  logic [N_LOG-1:0] ram_wr_addr, ram_rd_addr;
  logic [17:0] mem [N];

  ntt_coef_io #(.N_LOG(N_LOG), .Q(Q), .DATA_W(18)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .start_unload(start_unload),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_din(ram_wr_din), .ram_rd_addr(ram_rd_addr), .ram_rd_dout(ram_rd_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_din;
    rd_q <= mem[ram_rd_addr];
  end
  assign ram_rd_dout = rd_q;

  int tests = 0;
  int fails = 0;
  int wq_addr[$];
  int wq_data[$];
  int oq[$];
  int pops = 0;
  bit prev_stall = 0;
  int prev_data = 0;
  int exp_ram[N];
  int ld_in[N];
  int ld_exp[N];

  int tbl_in[N]  = '{-1, -65536, 65536, 0, 1, -2, 65535, -65535,
                     100, -100, 32768, -32768, 7, -7, 65000, -65000};
  int tbl_exp[N] = '{65536, 1, 65536, 0, 1, 65535, 65535, 2,
                     100, 65437, 32768, 32769, 7, 65530, 65000, 537};
  int rdy_pat[N] = '{1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1, 0};

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int addr_of(input int i);
`ifdef NTT_COEF_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < N_LOG; b++) r = r | (((i >> b) & 1) << (N_LOG - 1 - b));
    return r;
`else
    return i;
`endif
  endfunction

  // Monitor: RAM writes and output pops are checked against the queued expectations.
  always @(negedge clk) begin
    if (ram_wr_en) begin
      if (wq_addr.size() == 0) begin
        tests++; fails++;
        $display("FAIL wr_unexpected: got addr %0d expected no write", ram_wr_addr);
      end else begin
        check("wr_addr", int'(ram_wr_addr), wq_addr.pop_front());
        check("wr_data", int'(ram_wr_din), wq_data.pop_front());
      end
    end
    if (prev_stall) begin
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", int'(out_data), prev_data);
    end
    if (out_valid && out_ready) begin
      pops++;
      if (oq.size() == 0) begin
        tests++; fails++;
        $display("FAIL out_unexpected: got %0d expected no output", out_data);
      end else begin
        check("out_data", int'(out_data), oq.pop_front());
        check("unl_done", int'(done), (oq.size() == 0) ? 1 : 0);
      end
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = int'(out_data);
  end

  task automatic do_load(input bit both, input bit poke);
    start_load = 1'b1;
    start_unload = both;
    @(posedge clk); #1;
    start_load = 1'b0;
    start_unload = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data = 18'(ld_in[i]);
      start_unload = poke && (i == 3);
      wq_addr.push_back(addr_of(i));
      wq_data.push_back(ld_exp[i]);
      exp_ram[addr_of(i)] = ld_exp[i];
      @(negedge clk);
      check("ld_in_ready", int'(in_ready), 1);
      check("ld_busy", int'(busy), 1);
      check("ld_done", int'(done), (i == N - 1) ? 1 : 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start_unload = 1'b0;
    @(negedge clk);
    check("ld_busy_end", int'(busy), 0);
    check("ld_ready_end", int'(in_ready), 0);
    check("ld_no_unload", int'(out_valid), 0);
    check("ld_wq_empty", wq_addr.size(), 0);
  endtask

  // mode 0: ready held high; mode 1: ready pattern; mode 2: reset after 5 words
  task automatic do_unload(input int mode);
    int cyc;
    int lim;
    for (int i = 0; i < N; i++) oq.push_back(exp_ram[i]);
    pops = 0;
    lim = (mode == 2) ? 5 : N;
    out_ready = (mode != 1);
    start_unload = 1'b1;
    @(posedge clk); #1;
    start_unload = 1'b0;
    cyc = 0;
    while (pops < lim && cyc < 400) begin
      if (mode == 1) out_ready = rdy_pat[cyc % N][0];
      @(negedge clk);
      if (mode == 0 && cyc == 0) check("lat_c1_valid", int'(out_valid), 0);
      if (mode == 0 && cyc == 1) check("lat_c2_valid", int'(out_valid), 1);
      @(posedge clk); #1;
      cyc++;
    end
    check("unl_words", pops, lim);
    if (mode == 0) check("unl_cycles", cyc, N + 1);
    out_ready = 1'b0;
    if (mode == 2) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      oq.delete();
      @(negedge clk);
      check("abort_valid", int'(out_valid), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
    end else begin
      @(negedge clk);
      check("unl_busy_end", int'(busy), 0);
      check("unl_valid_end", int'(out_valid), 0);
      check("unl_oq_empty", oq.size(), 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    start_load = 1'b0;
    start_unload = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_wr_en", int'(ram_wr_en), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_wr_addr", int'(ram_wr_addr), 0);
    check("rst_wr_din", int'(ram_wr_din), 0);
    check("rst_rd_addr", int'(ram_rd_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < N; i++) begin
      ld_in[i] = i;
      ld_exp[i] = i;
    end
    do_load(1'b0, 1'b0);
    do_unload(0);

    for (int i = 0; i < N; i++) begin
      ld_in[i] = tbl_in[i];
      ld_exp[i] = tbl_exp[i];
    end
    do_load(1'b1, 1'b1);
    do_unload(1);
    do_unload(2);
    do_unload(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
